// File: rtl/store_queue.sv
// In-order store queue: holds dispatched stores until operands are ready and the
// store is at the ROB head, performs the memory write, then broadcasts completion.
module store_queue #(
    parameter int DEPTH         = 8,
    parameter int ROB_IDX_W     = 4,
    parameter int NUM_PHYS_REGS = 64,
    parameter int PREG_IDX_W    = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [ROB_IDX_W-1:0]     enq_rob_num,
    input  logic [PREG_IDX_W-1:0]    enq_ps1,
    input  logic [PREG_IDX_W-1:0]    enq_ps2,
    input  logic [31:0]              enq_imm,
    input  logic [2:0]               enq_funct3,
    input  logic [NUM_PHYS_REGS-1:0] valid_reg,
    output logic [PREG_IDX_W-1:0]    prf_raddr1,
    output logic [PREG_IDX_W-1:0]    prf_raddr2,
    input  logic [31:0]              prf_rdata1,
    input  logic [31:0]              prf_rdata2,
    input  logic                     rob_head_valid,
    input  logic [ROB_IDX_W-1:0]     rob_head_num,
    output logic                     dmem_write,
    output logic [31:0]              dmem_addr,
    output logic [3:0]               dmem_wmask,
    output logic [31:0]              dmem_wdata,
    input  logic                     dmem_resp,
    output logic                     store_cdb_valid,
    output logic [ROB_IDX_W-1:0]     store_cdb_rob_num
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_MEM_REQ, S_DONE} state_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0]  rob_num;
        logic [PREG_IDX_W-1:0] ps1;
        logic [PREG_IDX_W-1:0] ps2;
        logic [31:0]           imm;
        logic [2:0]            funct3;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [DEPTH-1:0]   r_vld;
    logic [PTR_W-1:0]   r_head, r_tail;
    logic [PTR_W:0]     r_count;
    state_t             r_state;

    logic                 r_dmem_write;
    logic [31:0]          r_dmem_addr, r_dmem_wdata;
    logic [3:0]           r_dmem_wmask;
    logic                 r_cdb_valid;
    logic [ROB_IDX_W-1:0] r_cdb_rob;

    entry_t           w_head;
    logic             w_enq, w_issue, w_pop, w_keep;
    logic [31:0]      w_ea, w_wdata;
    logic [3:0]       w_wmask;
    logic [PTR_W-1:0] w_head_nxt, w_tail_nxt;
    logic [PTR_W:0]   w_cnt_nxt;
    logic [DEPTH-1:0] w_vld_nxt;

    assign w_head     = r_mem[r_head];
    assign prf_raddr1 = w_head.ps1;
    assign prf_raddr2 = w_head.ps2;

    assign enq_ready = (r_count != CNT_FULL);
    assign w_enq     = enq_valid && enq_ready && !flush;
    assign w_pop     = (r_state == S_MEM_REQ) && dmem_resp;
    // A flush squashes everything except a head store that has already committed.
    assign w_keep    = (r_state == S_MEM_REQ) && !w_pop;
    assign w_issue   = (r_state == S_IDLE) && (r_count != '0) && !flush &&
                       valid_reg[w_head.ps1] && valid_reg[w_head.ps2] &&
                       rob_head_valid && (rob_head_num == w_head.rob_num);

    assign w_ea = prf_rdata1 + w_head.imm;

    always_comb begin
        w_wmask = 4'b0000;
        w_wdata = prf_rdata2;
        case (w_head.funct3)
            3'b000: begin
                w_wmask = 4'b0001 << w_ea[1:0];
                w_wdata = {4{prf_rdata2[7:0]}};
            end
            3'b001: begin
                w_wmask = 4'b0011 << {w_ea[1], 1'b0};
                w_wdata = {2{prf_rdata2[15:0]}};
            end
            3'b010: w_wmask = 4'b1111;
            default: w_wmask = 4'b0000;
        endcase
    end

    always_comb begin
        w_head_nxt = w_pop ? r_head + PTR_W'(1) : r_head;
        w_tail_nxt = r_tail;
        w_cnt_nxt  = r_count;
        w_vld_nxt  = r_vld;
        if (flush) begin
            w_vld_nxt  = '0;
            w_tail_nxt = w_keep ? r_head + PTR_W'(1) : w_head_nxt;
            w_cnt_nxt  = w_keep ? (PTR_W+1)'(1) : '0;
            if (w_keep)
                w_vld_nxt[r_head] = 1'b1;
        end else begin
            if (w_pop)
                w_vld_nxt[r_head] = 1'b0;
            if (w_enq) begin
                w_vld_nxt[r_tail] = 1'b1;
                w_tail_nxt        = r_tail + PTR_W'(1);
            end
            w_cnt_nxt = r_count + (PTR_W+1)'(w_enq) - (PTR_W+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq)
            r_mem[r_tail] <= '{rob_num: enq_rob_num, ps1: enq_ps1, ps2: enq_ps2,
                               imm: enq_imm, funct3: enq_funct3};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_cnt_nxt;
            r_vld   <= w_vld_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_dmem_write <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wmask <= '0;
            r_dmem_wdata <= '0;
            r_cdb_valid  <= 1'b0;
            r_cdb_rob    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cdb_valid <= 1'b0;
                    if (w_issue) begin
                        r_state      <= S_MEM_REQ;
                        r_dmem_write <= 1'b1;
                        r_dmem_addr  <= {w_ea[31:2], 2'b00};
                        r_dmem_wmask <= w_wmask;
                        r_dmem_wdata <= w_wdata;
                    end
                end
                S_MEM_REQ: begin
                    if (dmem_resp) begin
                        r_state      <= S_DONE;
                        r_dmem_write <= 1'b0;
                        r_dmem_wmask <= 4'b0000;
                        r_cdb_valid  <= 1'b1;
                        r_cdb_rob    <= w_head.rob_num;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cdb_valid <= 1'b0;
                end
            endcase
        end
    end

    assign dmem_write        = r_dmem_write;
    assign dmem_addr         = r_dmem_addr;
    assign dmem_wmask        = r_dmem_wmask;
    assign dmem_wdata        = r_dmem_wdata;
    assign store_cdb_valid   = r_cdb_valid;
    assign store_cdb_rob_num = r_cdb_rob;

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: queue-level reference model, per-cycle compare, directed
// scenarios with literal expectations, then randomized traffic.
module tb_store_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [3:0]  enq_rob_num = '0;
    logic [5:0]  enq_ps1 = '0, enq_ps2 = '0;
    logic [31:0] enq_imm = '0;
    logic [2:0]  enq_funct3 = '0;
    logic [63:0] valid_reg = '1;
    logic [5:0]  prf_raddr1, prf_raddr2;
    logic [31:0] prf_rdata1, prf_rdata2;
    logic        rob_head_valid = 1'b0;
    logic [3:0]  rob_head_num = '0;
    logic        dmem_write;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_resp = 1'b0;
    logic        store_cdb_valid;
    logic [3:0]  store_cdb_rob_num;

    logic [31:0] regs [64];
    assign prf_rdata1 = regs[prf_raddr1];
    assign prf_rdata2 = regs[prf_raddr2];

    store_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_rob_num(enq_rob_num),
        .enq_ps1(enq_ps1), .enq_ps2(enq_ps2), .enq_imm(enq_imm), .enq_funct3(enq_funct3),
        .valid_reg(valid_reg), .prf_raddr1(prf_raddr1), .prf_raddr2(prf_raddr2),
        .prf_rdata1(prf_rdata1), .prf_rdata2(prf_rdata2),
        .rob_head_valid(rob_head_valid), .rob_head_num(rob_head_num),
        .dmem_write(dmem_write), .dmem_addr(dmem_addr), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp),
        .store_cdb_valid(store_cdb_valid), .store_cdb_rob_num(store_cdb_rob_num)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rob;
        logic [5:0]  ps1;
        logic [5:0]  ps2;
        logic [31:0] imm;
        logic [2:0]  f3;
    } st_t;

    st_t         mq[$];
    logic [3:0]  bq[$];
    bit          m_busy = 0, m_cdb = 0;
    logic [3:0]  m_cdb_rob = '0;
    logic [31:0] m_addr = '0, m_data = '0;
    logic [3:0]  m_mask = '0;
    int          vectors = 0, errs = 0;
    int          resp_delay = 1;
    bit          auto_rob = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a FIFO of stores; one store may be in flight; completion takes a cycle.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            mq.delete();
            m_busy = 0; m_cdb = 0;
        end else begin
            int    pre;
            bit    pop, issue;
            logic [31:0] ea, rs2;
            pre   = mq.size();
            pop   = m_busy && dmem_resp;
            issue = !m_busy && !m_cdb && pre > 0 && !flush && rob_head_valid &&
                    valid_reg[mq[0].ps1] && valid_reg[mq[0].ps2] && rob_head_num == mq[0].rob;
            m_cdb = 0;
            if (pop) begin
                m_busy = 0; m_cdb = 1; m_cdb_rob = mq[0].rob;
                void'(mq.pop_front());
            end else if (issue) begin
                ea  = regs[mq[0].ps1] + mq[0].imm;
                rs2 = regs[mq[0].ps2];
                m_addr = ea & 32'hFFFF_FFFC;
                case (mq[0].f3)
                    3'd0: begin m_mask = 4'(1 << (ea % 4));   m_data = (rs2 & 32'hFF) * 32'h0101_0101; end
                    3'd1: begin m_mask = 4'(3 << (ea & 2));   m_data = (rs2 & 32'hFFFF) * 32'h0001_0001; end
                    3'd2: begin m_mask = 4'hF;                m_data = rs2; end
                    default: begin m_mask = 4'h0;             m_data = rs2; end
                endcase
                m_busy = 1;
            end
            if (flush) begin
                if (m_busy) begin
                    st_t f;
                    f = mq[0];
                    mq.delete();
                    mq.push_back(f);
                end else mq.delete();
            end else if (enq_valid && pre != 8) begin
                mq.push_back('{enq_rob_num, enq_ps1, enq_ps2, enq_imm, enq_funct3});
            end
        end
    end

    // Per-cycle compare against the model.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("enq_ready", {31'd0, enq_ready}, {31'd0, mq.size() != 8});
            chk("dmem_write", {31'd0, dmem_write}, {31'd0, m_busy});
            if (m_busy && dmem_write) begin
                chk("dmem_addr", dmem_addr, m_addr);
                chk("dmem_wmask", {28'd0, dmem_wmask}, {28'd0, m_mask});
                if (m_mask != 0) chk("dmem_wdata", dmem_wdata, m_data);
            end
            chk("cdb_valid", {31'd0, store_cdb_valid}, {31'd0, m_cdb});
            if (store_cdb_valid) begin
                bq.push_back(store_cdb_rob_num);
                if (m_cdb) chk("cdb_rob", {28'd0, store_cdb_rob_num}, {28'd0, m_cdb_rob});
            end
        end
    end

    // Memory responder and optional ROB-head follower.
    initial begin
        int rcnt = 0;
        forever begin
            @(negedge clk);
            if (rst || !dmem_write || dmem_resp) begin
                dmem_resp = 1'b0;
                if (rst || !dmem_write) rcnt = 0;
            end else if (rcnt >= resp_delay) begin
                dmem_resp = 1'b1;
                rcnt = 0;
            end else rcnt++;
            if (auto_rob) begin
                rob_head_valid = 1'b1;
                rob_head_num = (mq.size() > 0) ? mq[0].rob : 4'd0;
            end
        end
    end

    task automatic enq(input logic [3:0] r, input logic [5:0] p1, input logic [5:0] p2,
                       input logic [31:0] im, input logic [2:0] f);
        enq_valid = 1'b1; enq_rob_num = r; enq_ps1 = p1; enq_ps2 = p2;
        enq_imm = im; enq_funct3 = f;
        @(negedge clk);
        enq_valid = 1'b0;
    endtask

    task automatic wait_write(input string nm);
        for (int i = 0; i < 60; i++) begin
            if (dmem_write) return;
            @(negedge clk);
        end
        chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_cdb(input string nm);
        for (int i = 0; i < 60; i++) begin
            if (store_cdb_valid) return;
            @(negedge clk);
        end
        chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 600; i++) begin
            if (mq.size() == 0 && !m_busy && !store_cdb_valid) return;
            @(negedge clk);
        end
        chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        logic [3:0] exp_rob[$];
        for (int i = 0; i < 64; i++) regs[i] = $urandom;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_write", {31'd0, dmem_write}, 32'd0);
        chk("rst_cdb", {31'd0, store_cdb_valid}, 32'd0);
        chk("rst_ready", {31'd0, enq_ready}, 32'd1);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_mask", {28'd0, dmem_wmask}, 32'd0);

        // SW example, with commit-to-write latency
        regs[5] = 32'h1000; regs[6] = 32'hDEADBEEF;
        rob_head_valid = 1'b1; rob_head_num = 4'd3; resp_delay = 2;
        enq(4'd3, 6'd5, 6'd6, 32'd8, 3'b010);
        chk("sw_lat0", {31'd0, dmem_write}, 32'd0);
        @(negedge clk);
        chk("sw_lat1", {31'd0, dmem_write}, 32'd1);
        chk("sw_addr", dmem_addr, 32'h1008);
        chk("sw_mask", {28'd0, dmem_wmask}, 32'hF);
        chk("sw_data", dmem_wdata, 32'hDEADBEEF);
        wait_cdb("sw_cdb");
        chk("sw_cdb_rob", {28'd0, store_cdb_rob_num}, 32'd3);
        @(negedge clk);
        chk("sw_cdb_drop", {31'd0, store_cdb_valid}, 32'd0);

        // SB and SH lane placement
        regs[7] = 32'h2000; regs[8] = 32'h0000_00A5; regs[9] = 32'h0000_1234;
        rob_head_num = 4'd4;
        enq(4'd4, 6'd7, 6'd8, 32'd3, 3'b000);
        wait_write("sb");
        chk("sb_addr", dmem_addr, 32'h2000);
        chk("sb_mask", {28'd0, dmem_wmask}, 32'h8);
        chk("sb_data", dmem_wdata, 32'hA5A5A5A5);
        wait_cdb("sb_cdb");
        rob_head_num = 4'd5;
        enq(4'd5, 6'd7, 6'd9, 32'd2, 3'b001);
        wait_write("sh");
        chk("sh_mask", {28'd0, dmem_wmask}, 32'hC);
        chk("sh_data", dmem_wdata, 32'h12341234);
        wait_cdb("sh_cdb");
        @(negedge clk);

        // Operand-not-ready and ROB mismatch stalls
        valid_reg[10] = 1'b0; rob_head_num = 4'd6;
        enq(4'd6, 6'd7, 6'd10, 32'd0, 3'b010);
        repeat (10) begin chk("stall_ps2", {31'd0, dmem_write}, 32'd0); @(negedge clk); end
        valid_reg[10] = 1'b1; rob_head_num = 4'd7;
        repeat (10) begin chk("stall_rob", {31'd0, dmem_write}, 32'd0); @(negedge clk); end
        rob_head_num = 4'd6;
        @(negedge clk);
        chk("commit_lat", {31'd0, dmem_write}, 32'd1);
        wait_cdb("stall_cdb");
        @(negedge clk);

        // Fill to full, pop one, drain
        rob_head_valid = 1'b0;
        for (int i = 0; i < 8; i++) enq(4'(i), 6'd5, 6'd6, 32'(i * 4), 3'b010);
        chk("full_ready", {31'd0, enq_ready}, 32'd0);
        rob_head_valid = 1'b1; rob_head_num = 4'd0;
        wait_cdb("full_pop");
        chk("ready_after_pop", {31'd0, enq_ready}, 32'd1);
        auto_rob = 1;
        wait_drain("drain8");

        // 20 stores through the pointer wrap, broadcast in order
        bq.delete();
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 100 && !enq_ready; k++) @(negedge clk);
            exp_rob.push_back(4'((i + 3) % 16));
            enq(4'((i + 3) % 16), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                $urandom, 3'($urandom_range(0, 2)));
        end
        wait_drain("drain20");
        chk("wrap_count", bq.size(), 32'd20);
        for (int i = 0; i < 20 && i < bq.size(); i++)
            chk("wrap_order", {28'd0, bq[i]}, {28'd0, exp_rob[i]});
        auto_rob = 0;
        @(negedge clk);

        // Flush while the head is writing, 3 more queued
        rob_head_valid = 1'b0; resp_delay = 5;
        for (int i = 1; i <= 4; i++) enq(4'(i), 6'd5, 6'd6, 32'(i * 16), 3'b010);
        bq.delete();
        rob_head_valid = 1'b1; rob_head_num = 4'd1;
        wait_write("fl_write");
        rob_head_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_ready", {31'd0, enq_ready}, 32'd1);
        wait_cdb("fl_cdb");
        chk("fl_cdb_rob", {28'd0, store_cdb_rob_num}, 32'd1);
        rob_head_valid = 1'b1;
        for (int r = 2; r <= 4; r++) begin
            rob_head_num = 4'(r);
            repeat (3) begin @(negedge clk); chk("fl_no_write", {31'd0, dmem_write}, 32'd0); end
        end
        chk("fl_bcast", bq.size(), 32'd1);
        rob_head_valid = 1'b0;

        // Asynchronous reset during a pending write with the queue full
        resp_delay = 40;
        for (int i = 8; i < 16; i++) enq(4'(i), 6'd5, 6'd6, 32'd0, 3'b010);
        rob_head_valid = 1'b1; rob_head_num = 4'd8;
        wait_write("rst_write_wait");
        chk("pre_rst_ready", {31'd0, enq_ready}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_write", {31'd0, dmem_write}, 32'd0);
        chk("async_cdb", {31'd0, store_cdb_valid}, 32'd0);
        chk("async_ready", {31'd0, enq_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0; rob_head_valid = 1'b0; resp_delay = 1;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            enq_valid   = 1'($urandom_range(0, 1));
            enq_rob_num = 4'($urandom);
            enq_ps1     = 6'($urandom);
            enq_ps2     = 6'($urandom);
            enq_imm     = $urandom;
            enq_funct3  = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            flush       = ($urandom_range(0, 49) == 0);
            rob_head_valid = !flush && ($urandom_range(0, 4) != 0);
            rob_head_num = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[0].rob : 4'($urandom);
            valid_reg   = ~({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
            if ($urandom_range(0, 7) == 0) regs[$urandom_range(0, 63)] = $urandom;
            resp_delay  = $urandom_range(0, 3);
        end
        @(negedge clk);
        enq_valid = 1'b0; flush = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
